// File: rtl/wrr_pkg.sv
// wrr_pkg: shared widths, types and the priority-to-weight mapping for the WRR priority table.
package wrr_pkg;
  localparam int PRIORITY_W = 4;
  localparam int CREDIT_W = PRIORITY_W + 1;
  typedef logic [PRIORITY_W-1:0] prio_t;
  typedef logic [CREDIT_W-1:0] credit_t;
  function automatic credit_t weight_of(prio_t p);
    return credit_t'(p) + credit_t'(1);
  endfunction
endpackage

// File: rtl/wrr_credit_cell.sv
// wrr_credit_cell: one requester's priority entry and credit counter.
module wrr_credit_cell
  import wrr_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  upt,
  input  prio_t prio,
  input  logic  gnt,
  input  logic  reload,
  output prio_t prio_q,
  output logic  credit_ok
);
  credit_t credit, post_gnt, w;
  prio_t np;
  always_comb begin
    np = upt ? prio : prio_q;
    w = weight_of(np);
    post_gnt = (gnt && credit != '0) ? credit - credit_t'(1) : credit;
  end
  // A same-cycle update clamps the credit so a lowered weight bites immediately.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prio_q <= '0;
      credit <= credit_t'(1);
    end else begin
      if (upt) prio_q <= prio;
      credit <= reload ? (gnt ? credit_t'(np) : w) : (upt && w < post_gnt) ? w : post_gnt;
    end
  assign credit_ok = credit != '0;
endmodule

// File: rtl/wrr_prio_table.sv
// wrr_prio_table: per-requester priority table and credit counters feeding the WRR arbiter.
module wrr_prio_table
  import wrr_pkg::*;
#(
  parameter int N = 32,
  parameter int ID_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  prio_t              prio,
  input  logic [ID_BITS-1:0] prio_id,
  input  logic               prio_upt,
  input  logic [N-1:0]       req,
  input  logic               gnt_vld,
  input  logic [ID_BITS-1:0] gnt_id,
  output logic [N-1:0]       credit_ok,
  output logic               reload,
  output logic               upt_drop,
  input  logic [ID_BITS-1:0] rd_id,
  output prio_t              rd_prio
);
  localparam logic [ID_BITS:0] LIM = (ID_BITS + 1)'(N);
  logic upt_ok, gnt_ok, rd_ok, reload_c;
  prio_t prio_tbl [N];
  assign upt_ok = prio_upt && ({1'b0, prio_id} < LIM);
  assign gnt_ok = gnt_vld && ({1'b0, gnt_id} < LIM);
  assign rd_ok = {1'b0, rd_id} < LIM;
  // Reload once every active requester has run out of credit.
  assign reload_c = |req && ~|(req & credit_ok);
  assign rd_prio = rd_ok ? prio_tbl[rd_id] : '0;
  for (genvar i = 0; i < N; i++) begin : g_cell
    wrr_credit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .upt      (upt_ok && prio_id == ID_BITS'(i)),
      .prio     (prio),
      .gnt      (gnt_ok && gnt_id == ID_BITS'(i)),
      .reload   (reload_c),
      .prio_q   (prio_tbl[i]),
      .credit_ok(credit_ok[i])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      reload <= 1'b0;
      upt_drop <= 1'b0;
    end else begin
      reload <= reload_c;
      upt_drop <= prio_upt && !upt_ok;
    end
endmodule
